// File: rtl/mm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_arb_pkg
// Description : Shared types, constants and width helper for mm_job_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ENGRST = 3'd4
    } mm_arb_state_t;

    localparam int c_RESULT_WIDTH = 24;

    // Width able to hold the values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mm_arb_pkg
`default_nettype wire

// File: rtl/mm_job_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches req upward from
//               ptr and returns a one-hot winner plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mm_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic [PTR_W-1:0]   o_index
);

    localparam int c_SW = PTR_W + 1;

    logic [c_SW-1:0]  w_sum;
    logic [PTR_W-1:0] w_sel;
    logic             w_found;

    always_comb begin
        o_winner = '0;
        o_index  = '0;
        w_sum    = '0;
        w_sel    = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i modulo NUM_REQ without a divider
            w_sum = {1'b0, i_ptr} + c_SW'(i);
            if (w_sum >= c_SW'(NUM_REQ)) begin
                w_sum = w_sum - c_SW'(NUM_REQ);
            end
            w_sel = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_sel]) begin
                w_found         = 1'b1;
                o_winner[w_sel] = 1'b1;
                o_index         = w_sel;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mm_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mm_job_arbiter
// Description : Round-robin arbiter sharing one matmul engine among NUM_REQ
//               requesters. Optional WAIT watchdog: define MM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_job_arbiter
    import mm_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int RESULT_WIDTH   = c_RESULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ENG_RST_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    eng_start,
    input  logic                    eng_done,
    input  logic [RESULT_WIDTH-1:0] eng_sum,
    output logic                    eng_rst_n,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [RESULT_WIDTH-1:0] rsp_sum,
    output logic                    busy,
    output logic                    timeout
);

    localparam int c_PTR_W = idx_width(NUM_REQ);
    // One counter serves both the ENGRST hold and the WAIT watchdog.
    localparam int c_CNT_W = idx_width((TIMEOUT_CYCLES > ENG_RST_CYCLES) ?
                                       TIMEOUT_CYCLES : ENG_RST_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ERST_LAST = c_CNT_W'(ENG_RST_CYCLES - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX  = c_PTR_W'(NUM_REQ - 1);
`ifdef MM_ARB_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    mm_arb_state_t           r_state;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [c_PTR_W-1:0]      r_win_idx;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [NUM_REQ-1:0]      r_gnt;
    logic                    r_eng_start;
    logic                    r_eng_rst_n;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [RESULT_WIDTH-1:0] r_rsp_sum;
    logic                    r_timeout;

    logic [NUM_REQ-1:0]      w_winner;
    logic [c_PTR_W-1:0]      w_win_idx;
    logic [c_PTR_W-1:0]      w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_index  (w_win_idx)
    );

    assign w_ptr_next = (r_win_idx == c_LAST_IDX) ? '0 : r_win_idx + c_PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_win_idx   <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_eng_start <= 1'b0;
            r_eng_rst_n <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_eng_rst_n <= 1'b1;
                    r_cnt       <= '0;
                    if (|req) begin
                        r_gnt       <= w_winner;
                        r_win_idx   <= w_win_idx;
                        r_eng_start <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_rsp_sum   <= eng_sum;
                        r_rsp_valid <= r_gnt;
                        r_state     <= ST_RESP;
                    end
`ifdef MM_ARB_TIMEOUT_EN
                    else if (r_cnt == c_TO_LAST) begin
                        r_timeout   <= 1'b1;
                        r_eng_rst_n <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_ENGRST;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    r_eng_rst_n <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_ENGRST;
                end
                ST_ENGRST: begin
                    if (r_cnt == c_ERST_LAST) begin
                        r_eng_rst_n <= 1'b1;
                        r_gnt       <= '0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign eng_start = r_eng_start;
    assign eng_rst_n = r_eng_rst_n;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = (r_state != ST_IDLE);
    assign timeout   = r_timeout;

endmodule : mm_job_arbiter
`default_nettype wire

// File: tb/tb_mm_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_job_arbiter
// Description : Self-checking bench for mm_job_arbiter with an engine model
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int RW      = 24;

    logic              clk;
    logic              rst_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic              eng_start;
    logic              eng_done;
    logic [RW-1:0]     eng_sum;
    logic              eng_rst_n;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [RW-1:0]     rsp_sum;
    logic              busy;
    logic              timeout;

    mm_job_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .RESULT_WIDTH   (RW),
        .TIMEOUT_CYCLES (64),
        .ENG_RST_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .eng_sum   (eng_sum),
        .eng_rst_n (eng_rst_n),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [NUM_REQ-1:0] exp_gnt;
        int                 delay;
        logic [RW-1:0]      sum;
    } vec_t;

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic [RW-1:0]      sum;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   eng_delay = 1;
    logic [RW-1:0] eng_value = '0;
    int   eng_cnt = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine model: done rises eng_delay cycles after start, cleared by eng_rst_n.
    initial begin
        eng_done = 1'b0;
        eng_sum  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !eng_rst_n) begin
                eng_done = 1'b0;
                eng_cnt  = -1;
            end else if (eng_start) begin
                eng_cnt = eng_delay;
                eng_sum = ~eng_value;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_sum  = eng_value;
                end
            end
        end
    end

    // Monitor: one-hot properties, scoreboard pop on rsp_valid, eng_rst_n width.
    initial begin
        int   lowlen;
        logic prev;
        exp_t e;
        lowlen = 0;
        prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lowlen = 0;
                prev   = 1'b0;
            end else begin
                check("gnt_onehot", 32'($onehot0(gnt)), 1);
                check("rsp_onehot", 32'($onehot0(rsp_valid)), 1);
                if (rsp_valid != '0) begin
                    if (sb_q.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_valid", 32'(rsp_valid), 32'(e.gnt));
                        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    end
                end
                if (!eng_rst_n) begin
                    if (prev) lowlen = 1;
                    else if (lowlen > 0) lowlen++;
                end else if (!prev && lowlen > 0) begin
                    check("eng_rst_len", 32'(lowlen), 2);
                    lowlen = 0;
                end
                prev = eng_rst_n;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit, checks=%0d", n_checks);
        $fatal(1, "simulation time limit reached");
    end

    task automatic wait_rsp(input int limit, output int cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_wait", 32'(rsp_valid != '0), 1);
    endtask

    task automatic wait_start(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!eng_start && cyc < limit);
        check("start_wait", 32'(eng_start), 1);
    endtask

    task automatic wait_idle(input int limit);
        int cyc;
        cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_wait", 32'(busy), 0);
    endtask

    task automatic run_job(input vec_t v);
        int   cyc;
        exp_t e;
        eng_delay = v.delay;
        eng_value = v.sum;
        e.gnt = v.exp_gnt;
        e.sum = v.sum;
        sb_q.push_back(e);
        @(negedge clk);
        req = v.req;
        @(negedge clk);
        check("grant", 32'(gnt), 32'(v.exp_gnt));
        check("start_pulse", 32'(eng_start), 1);
        check("busy_job", 32'(busy), 1);
        @(negedge clk);
        check("start_single", 32'(eng_start), 0);
        wait_rsp(v.delay + 20, cyc);
        check("rsp_latency", 32'(cyc + 1), 32'(v.delay + 1));
        req = '0;
        @(negedge clk);
        check("engrst_1", 32'(eng_rst_n), 0);
        check("gnt_hold", 32'(gnt), 32'(v.exp_gnt));
        @(negedge clk);
        check("engrst_2", 32'(eng_rst_n), 0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_gnt", 32'(gnt), 0);
        check("engrst_release", 32'(eng_rst_n), 1);
        check("rsp_sum_hold", 32'(rsp_sum), 32'(v.sum));
    endtask

    initial begin
        vec_t vecs[8];
        logic [NUM_REQ-1:0] order[8];
        exp_t e;
        int   cyc;

        vecs[0] = '{req: 4'b0010, exp_gnt: 4'b0010, delay: 20, sum: 24'h0001F4};
        vecs[1] = '{req: 4'b0011, exp_gnt: 4'b0001, delay: 5,  sum: 24'h000123};
        vecs[2] = '{req: 4'b0011, exp_gnt: 4'b0010, delay: 3,  sum: 24'hFFFFFF};
        vecs[3] = '{req: 4'b1000, exp_gnt: 4'b1000, delay: 1,  sum: 24'h000000};
        vecs[4] = '{req: 4'b1100, exp_gnt: 4'b0100, delay: 7,  sum: 24'hABCDEF};
        vecs[5] = '{req: 4'b0101, exp_gnt: 4'b0001, delay: 2,  sum: 24'h800000};
        vecs[6] = '{req: 4'b0101, exp_gnt: 4'b0100, delay: 4,  sum: 24'h123456};
        vecs[7] = '{req: 4'b1111, exp_gnt: 4'b1000, delay: 1,  sum: 24'h7FFFFF};
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_eng_start", 32'(eng_start), 0);
        check("rst_eng_rst_n", 32'(eng_rst_n), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sum", 32'(rsp_sum), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_eng", 32'(eng_rst_n), 1);

        // Fairness with every requester held
        eng_delay = 2;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            eng_value = 24'h000100 + 24'(k);
            e.gnt = order[k];
            e.sum = eng_value;
            sb_q.push_back(e);
            wait_start(20, cyc);
            check("fair_order", 32'(gnt), 32'(order[k]));
            @(negedge clk);
            wait_rsp(30, cyc);
            if (k == 7) req = '0;
        end
        wait_idle(20);

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Contention: req[2] rises while requester 0 is in WAIT
        eng_delay = 10;
        eng_value = 24'h00C0DE;
        e.gnt = 4'b0001; e.sum = 24'h00C0DE;
        sb_q.push_back(e);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        check("cont_gnt0", 32'(gnt), 1);
        repeat (4) @(negedge clk);
        req = 4'b0101;
        check("cont_gnt_hold", 32'(gnt), 1);
        wait_rsp(30, cyc);
        req = 4'b0100;
        eng_delay = 3;
        eng_value = 24'h0BEEF0;
        e.gnt = 4'b0100; e.sum = 24'h0BEEF0;
        sb_q.push_back(e);
        wait_start(20, cyc);
        check("cont_gnt_delay", 32'(cyc), 4);
        check("cont_gnt2", 32'(gnt), 32'(4'b0100));
        @(negedge clk);
        wait_rsp(30, cyc);
        req = '0;
        wait_idle(20);

        // Requester drops req during WAIT
        eng_delay = 6;
        eng_value = 24'h00D00D;
        e.gnt = 4'b0010; e.sum = 24'h00D00D;
        sb_q.push_back(e);
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        check("drop_gnt", 32'(gnt), 32'(4'b0010));
        repeat (2) @(negedge clk);
        req = '0;
        wait_rsp(30, cyc);
        check("drop_rsp", 32'(rsp_valid), 32'(4'b0010));
        wait_idle(20);
        run_job('{req: 4'b0110, exp_gnt: 4'b0100, delay: 2, sum: 24'h0F0F0F});

        // Reset asserted in WAIT drops the job
        eng_delay = 30;
        eng_value = 24'h0BAD00;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        check("rstmid_gnt", 32'(gnt), 32'(4'b0100));
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_gnt0", 32'(gnt), 0);
        check("rstmid_eng_rst", 32'(eng_rst_n), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_rsp", 32'(rsp_valid), 0);
        req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_release", 32'(eng_rst_n), 1);
        run_job('{req: 4'b1010, exp_gnt: 4'b0010, delay: 3, sum: 24'h00ABCD});
        run_job('{req: 4'b0001, exp_gnt: 4'b0001, delay: 2, sum: 24'h000777});

`ifdef MM_ARB_TIMEOUT_EN
        eng_delay = -1;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        check("to_gnt", 32'(gnt), 1);
        cyc = 0;
        while (!timeout && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycle", 32'(cyc), 65);
        check("to_eng_rst", 32'(eng_rst_n), 0);
        req = '0;
        wait_idle(20);
        check("to_sticky", 32'(timeout), 1);
        run_job('{req: 4'b0011, exp_gnt: 4'b0010, delay: 3, sum: 24'h00AA55});
`else
        check("timeout_tied", 32'(timeout), 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mm_job_arbiter
`default_nettype wire
